// File: rtl/mac_tx_frame_feeder.sv
// mac_tx_frame_feeder
//
// Store-and-forward transmit feeder on the user side of an Ethernet MAC.
// It buffers one complete frame and then streams it to the MAC. It replays the
// frame from byte 0 whenever the MAC requests a retransmit. It discards frames
// that are oversize or that run out of retries.
//
// Ports
//   tx_mac_clk      sole clock (MAC transmit clock)
//   reset           synchronous, active-high reset
//   wr_valid/data   write-side byte stream from the bridge datapath
//   wr_last         final byte of the frame being written
//   wr_err          per-byte error flag; any set byte marks the frame bad
//   wr_ready        high while the buffer is filling
//   tx_mac_valid    byte valid to MAC (registered)
//   tx_mac_data     byte to MAC (registered)
//   tx_mac_last     final byte of the frame (registered)
//   tx_mac_error    frame is bad; only asserted together with tx_mac_last
//   tx_mac_ready    MAC accepts the presented byte
//   tx_retransmit   one-cycle request to resend from byte 0
//   frame_sent      one-cycle pulse when a frame is released after sending
//   frame_dropped   one-cycle pulse when a frame is discarded

module mac_tx_frame_feeder #(
    parameter int unsigned MAX_FRAME   = 2048,
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned MAX_RETRY   = 15,
    parameter int unsigned RETX_WINDOW = 64
) (
    input  logic       tx_mac_clk,
    input  logic       reset,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    input  logic       wr_last,
    input  logic       wr_err,
    output logic       wr_ready,
    output logic       tx_mac_valid,
    output logic [7:0] tx_mac_data,
    output logic       tx_mac_last,
    output logic       tx_mac_error,
    input  logic       tx_mac_ready,
    input  logic       tx_retransmit,
    output logic       frame_sent,
    output logic       frame_dropped
);

    localparam int unsigned PtrW   = ADDR_W + 1;
    localparam int unsigned RetryW = ($clog2(MAX_RETRY + 1) > 4) ? $clog2(MAX_RETRY + 1) : 4;
    localparam int unsigned HoldW  = ($clog2(RETX_WINDOW + 1) > 1) ? $clog2(RETX_WINDOW + 1) : 1;

    localparam logic [PtrW-1:0]   MaxFrameP = PtrW'(MAX_FRAME);
    localparam logic [RetryW-1:0] MaxRetryP = RetryW'(MAX_RETRY);
    localparam logic [HoldW-1:0]  WindowP   = HoldW'(RETX_WINDOW);

    typedef enum logic [1:0] {StFill, StSend, StHold} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   len_q, len_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    // One extra idle cycle after a retransmit before byte 0 is reloaded.
    logic              wait_q, wait_d;
    logic              valid_q, valid_d;
    logic [7:0]        data_q, data_d;
    logic              last_q, last_d;
    logic              error_q, error_d;
    logic              sent_q, sent_d;
    logic              dropped_q, dropped_d;

    logic              wr_en;
    logic              xfer;
    logic [7:0]        mem_rd;

    logic [7:0] mem [MAX_FRAME];

    always_ff @(posedge tx_mac_clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign mem_rd = mem[rd_ptr_q[ADDR_W-1:0]];

    always_ff @(posedge tx_mac_clk) begin
        if (reset) begin
            state_q   <= StFill;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            retry_q   <= '0;
            hold_q    <= '0;
            wait_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            error_q   <= 1'b0;
            sent_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            len_q     <= len_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            retry_q   <= retry_d;
            hold_q    <= hold_d;
            wait_q    <= wait_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            last_q    <= last_d;
            error_q   <= error_d;
            sent_q    <= sent_d;
            dropped_q <= dropped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        len_d     = len_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        retry_d   = retry_q;
        hold_d    = hold_q;
        wait_d    = wait_q;
        valid_d   = valid_q;
        data_d    = data_q;
        last_d    = last_q;
        error_d   = error_q;
        sent_d    = 1'b0;
        dropped_d = 1'b0;
        wr_en     = 1'b0;
        xfer      = valid_q & tx_mac_ready;

        unique case (state_q)
            StFill: begin
                if (wr_valid) begin
                    err_d = err_q | wr_err;
                    if (!ovf_q && (wr_ptr_q < MaxFrameP)) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PtrW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (wr_last) begin
                        // The last byte itself may be the first one past the buffer.
                        if (ovf_q || (wr_ptr_q >= MaxFrameP)) begin
                            dropped_d = 1'b1;
                            wr_ptr_d  = '0;
                            ovf_d     = 1'b0;
                            err_d     = 1'b0;
                        end else begin
                            len_d    = wr_ptr_q + PtrW'(1);
                            wr_ptr_d = '0;
                            ovf_d    = 1'b0;
                            rd_ptr_d = '0;
                            retry_d  = '0;
                            wait_d   = 1'b0;
                            state_d  = StSend;
                        end
                    end
                end
            end

            StSend: begin
                if (xfer && last_q) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    error_d = 1'b0;
                    hold_d  = WindowP;
                    state_d = StHold;
                end else if (wait_q) begin
                    wait_d = 1'b0;
                end else if (!valid_q || tx_mac_ready) begin
                    // Output register is empty or being drained: prefetch the next byte.
                    if (rd_ptr_q < len_q) begin
                        valid_d  = 1'b1;
                        data_d   = mem_rd;
                        last_d   = (rd_ptr_q == (len_q - PtrW'(1)));
                        error_d  = (rd_ptr_q == (len_q - PtrW'(1))) & err_q;
                        rd_ptr_d = rd_ptr_q + PtrW'(1);
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end

            StHold: begin
                if (hold_q <= HoldW'(1)) begin
                    sent_d   = 1'b1;
                    state_d  = StFill;
                    hold_d   = '0;
                    err_d    = 1'b0;
                    rd_ptr_d = '0;
                    retry_d  = '0;
                    len_d    = '0;
                end else begin
                    hold_d = hold_q - HoldW'(1);
                end
            end

            default: begin
                state_d = StFill;
            end
        endcase

        // A retransmit overrides whatever SEND/HOLD decided this cycle, including a
        // last-byte handshake or the final HOLD count.
        if (tx_retransmit && (state_q != StFill)) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            error_d = 1'b0;
            sent_d  = 1'b0;
            hold_d  = '0;
            if (retry_q == MaxRetryP) begin
                dropped_d = 1'b1;
                state_d   = StFill;
                wr_ptr_d  = '0;
                ovf_d     = 1'b0;
                err_d     = 1'b0;
                rd_ptr_d  = '0;
                retry_d   = '0;
                len_d     = '0;
                wait_d    = 1'b0;
            end else begin
                retry_d  = retry_q + RetryW'(1);
                rd_ptr_d = '0;
                wait_d   = 1'b1;
                state_d  = StSend;
            end
        end
    end

    assign wr_ready      = (state_q == StFill);
    assign tx_mac_valid  = valid_q;
    assign tx_mac_data   = data_q;
    assign tx_mac_last   = last_q;
    assign tx_mac_error  = error_q;
    assign frame_sent    = sent_q;
    assign frame_dropped = dropped_q;

endmodule

// File: tb/tb_mac_tx_frame_feeder.sv
// Scoreboard bench for mac_tx_frame_feeder: stimulus pushes expected MAC bytes
// into a queue, a negedge monitor pops and compares on each MAC handshake.

module tb_mac_tx_frame_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_last;
    logic       wr_err;
    logic       wr_ready;
    logic       tx_mac_valid;
    logic [7:0] tx_mac_data;
    logic       tx_mac_last;
    logic       tx_mac_error;
    logic       tx_mac_ready;
    logic       tx_retransmit;
    logic       frame_sent;
    logic       frame_dropped;

    always #5 clk = ~clk;

    mac_tx_frame_feeder dut (
        .tx_mac_clk    (clk),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_last       (wr_last),
        .wr_err        (wr_err),
        .wr_ready      (wr_ready),
        .tx_mac_valid  (tx_mac_valid),
        .tx_mac_data   (tx_mac_data),
        .tx_mac_last   (tx_mac_last),
        .tx_mac_error  (tx_mac_error),
        .tx_mac_ready  (tx_mac_ready),
        .tx_retransmit (tx_retransmit),
        .frame_sent    (frame_sent),
        .frame_dropped (frame_dropped)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [9:0] exp_q[$];   // {data, last, error}

    int xfer_count    = 0;
    int last_count    = 0;
    int sent_count    = 0;
    int dropped_count = 0;
    int sent_cyc      = 0;
    int last_xfer_cyc = 0;

    logic       stab_v = 1'b0;
    logic [9:0] stab_d = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset) begin
            stab_v = 1'b0;
        end else begin
            if (frame_sent) begin
                sent_count++;
                sent_cyc = cyc;
                check("wr_ready_with_sent", {31'd0, wr_ready}, 32'd1);
            end
            if (frame_dropped) dropped_count++;
            if (stab_v) begin
                check("stall_valid_held", {31'd0, tx_mac_valid}, 32'd1);
                check("stall_data_held", {22'd0, tx_mac_data, tx_mac_last, tx_mac_error},
                      {22'd0, stab_d});
            end
            if (tx_mac_valid && tx_mac_ready && !tx_retransmit) begin
                check("xfer_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    check("xfer_byte", {22'd0, tx_mac_data, tx_mac_last, tx_mac_error},
                          {22'd0, exp_q.pop_front()});
                end
                xfer_count++;
                if (tx_mac_last) begin
                    last_count++;
                    last_xfer_cyc = cyc;
                end
            end
            stab_v = tx_mac_valid && !tx_mac_ready && !tx_retransmit;
            stab_d = {tx_mac_data, tx_mac_last, tx_mac_error};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int len, input logic [7:0] base, input int err_idx);
        logic [7:0] d;
        logic       lst;
        for (int i = 0; i < len; i++) begin
            d   = base + 8'(i);
            lst = (i == len - 1);
            exp_q.push_back({d, lst, lst && (err_idx >= 0) && (err_idx < len)});
        end
    endtask

    task automatic write_frame(input int len, input logic [7:0] base, input int err_idx);
        for (int i = 0; i < len; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + 8'(i);
            wr_last  = (i == len - 1);
            wr_err   = (i == err_idx);
            tick();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        wr_err   = 1'b0;
    endtask

    // Called in the cycle after the wr_last handshake.
    task automatic check_start(input string name);
        @(negedge clk);
        check({name, "_idle_k1"}, {31'd0, tx_mac_valid}, 32'd0);
        tick();
        @(negedge clk);
        check({name, "_valid_k2"}, {31'd0, tx_mac_valid}, 32'd1);
    endtask

    task automatic wait_sent(input string name, input int target, input int budget);
        int n = 0;
        while (sent_count < target && n < budget) begin
            tick();
            n++;
        end
        check({name, "_sent_seen"}, {31'd0, sent_count >= target}, 32'd1);
    endtask

    task automatic wait_xfers(input string name, input int target, input int budget);
        int n = 0;
        while (xfer_count < target && n < budget) begin
            tick();
            n++;
        end
        check({name, "_xfers_seen"}, {31'd0, xfer_count >= target}, 32'd1);
    endtask

    task automatic retransmit_pulse(input logic refill, input int len, input logic [7:0] base);
        tx_retransmit = 1'b1;
        exp_q.delete();
        if (refill) push_frame(len, base, -1);
        tick();
        tx_retransmit = 1'b0;
    endtask

    // Called in the cycle after the retransmit cycle, with tx_mac_ready=1.
    task automatic check_replay(input string name, input logic [7:0] base);
        @(negedge clk);
        check({name, "_idle1"}, {31'd0, tx_mac_valid}, 32'd0);
        tick();
        @(negedge clk);
        check({name, "_idle2"}, {31'd0, tx_mac_valid}, 32'd0);
        tick();
        @(negedge clk);
        check({name, "_byte0"}, {23'd0, tx_mac_valid, tx_mac_data}, {23'd0, 1'b1, base});
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0, x0, l0;
        logic [3:0] pat;

        reset = 1'b1;
        wr_valid = 1'b0;
        wr_data = '0;
        wr_last = 1'b0;
        wr_err = 1'b0;
        tx_mac_ready = 1'b1;
        tx_retransmit = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("rst_valid", {31'd0, tx_mac_valid}, 32'd0);
        check("rst_last", {31'd0, tx_mac_last}, 32'd0);
        check("rst_error", {31'd0, tx_mac_error}, 32'd0);
        check("rst_data", {24'd0, tx_mac_data}, 32'd0);
        check("rst_sent", {31'd0, frame_sent}, 32'd0);
        check("rst_dropped", {31'd0, frame_dropped}, 32'd0);
        tick();

        // Basic 60-byte send
        s0 = sent_count;
        x0 = xfer_count;
        push_frame(60, 8'h00, -1);
        write_frame(60, 8'h00, -1);
        check_start("basic");
        wait_sent("basic", s0 + 1, 300);
        check("basic_sent_delay", sent_cyc - last_xfer_cyc, 65);
        check("basic_xfers", xfer_count - x0, 60);
        check("basic_queue_empty", exp_q.size(), 0);

        // Backpressure 1,0,0,1
        s0 = sent_count;
        x0 = xfer_count;
        pat = 4'b1001;
        push_frame(60, 8'h00, -1);
        write_frame(60, 8'h00, -1);
        for (int i = 0; i < 600 && sent_count == s0; i++) begin
            tx_mac_ready = pat[i % 4];
            tick();
        end
        tx_mac_ready = 1'b1;
        check("bp_sent", sent_count - s0, 1);
        check("bp_xfers", xfer_count - x0, 60);
        check("bp_queue_empty", exp_q.size(), 0);

        // Retransmit mid-frame and during HOLD
        s0 = sent_count;
        d0 = dropped_count;
        x0 = xfer_count;
        l0 = last_count;
        push_frame(60, 8'h00, -1);
        write_frame(60, 8'h00, -1);
        wait_xfers("retx_mid", x0 + 21, 100);
        retransmit_pulse(1'b1, 60, 8'h00);
        check_replay("retx_mid", 8'h00);
        while (last_count == l0 && cyc < 100000) tick();
        check("retx_reached_hold", {31'd0, last_count > l0}, 32'd1);
        repeat (10) tick();
        retransmit_pulse(1'b1, 60, 8'h00);
        check_replay("retx_hold", 8'h00);
        wait_sent("retx", s0 + 1, 300);
        check("retx_sent_delay", sent_cyc - last_xfer_cyc, 65);
        check("retx_queue_empty", exp_q.size(), 0);
        repeat (80) tick();
        check("retx_sent_once", sent_count - s0, 1);
        check("retx_no_drop", dropped_count - d0, 0);

        // Retry limit: 16 retransmits on an 8-byte frame
        s0 = sent_count;
        d0 = dropped_count;
        push_frame(8, 8'h10, -1);
        write_frame(8, 8'h10, -1);
        repeat (5) tick();
        for (int r = 0; r < 15; r++) begin
            retransmit_pulse(1'b1, 8, 8'h10);
            repeat (3) tick();
        end
        retransmit_pulse(1'b0, 8, 8'h10);
        @(negedge clk);
        check("retry_dropped", {31'd0, frame_dropped}, 32'd1);
        check("retry_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("retry_valid_low", {31'd0, tx_mac_valid}, 32'd0);
        tick();
        @(negedge clk);
        check("retry_drop_width", {31'd0, frame_dropped}, 32'd0);
        repeat (80) tick();
        check("retry_no_sent", sent_count - s0, 0);
        check("retry_drop_count", dropped_count - d0, 1);

        // Oversize 2049-byte frame
        x0 = xfer_count;
        write_frame(2049, 8'h00, -1);
        @(negedge clk);
        check("ovf_dropped", {31'd0, frame_dropped}, 32'd1);
        check("ovf_wr_ready", {31'd0, wr_ready}, 32'd1);
        repeat (10) tick();
        @(negedge clk);
        check("ovf_valid_low", {31'd0, tx_mac_valid}, 32'd0);
        check("ovf_no_xfer", xfer_count - x0, 0);
        tick();

        // 64-byte frame with wr_err on byte 10
        s0 = sent_count;
        push_frame(64, 8'h20, 10);
        write_frame(64, 8'h20, 10);
        check_start("err");
        wait_sent("err", s0 + 1, 300);
        check("err_queue_empty", exp_q.size(), 0);

        // Reset mid-SEND
        x0 = xfer_count;
        push_frame(64, 8'h80, -1);
        write_frame(64, 8'h80, -1);
        wait_xfers("rst_mid", x0 + 31, 100);
        s0 = sent_count;
        d0 = dropped_count;
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_valid", {31'd0, tx_mac_valid}, 32'd0);
        check("rstmid_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("rstmid_sent", {31'd0, frame_sent}, 32'd0);
        check("rstmid_dropped", {31'd0, frame_dropped}, 32'd0);
        repeat (5) tick();
        check("rstmid_no_pulses", (sent_count - s0) + (dropped_count - d0), 0);
        push_frame(64, 8'h40, -1);
        write_frame(64, 8'h40, -1);
        check_start("after_rst");
        wait_sent("after_rst", s0 + 1, 300);
        check("after_rst_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
